// File: rtl/img_pkg.sv
// Shared types for the luma-path image blocks.
package img_pkg;

  localparam int IMG_DW = 8;

  typedef enum logic [1:0] {
    MODE_BYPASS = 2'd0,
    MODE_GX     = 2'd1,
    MODE_GY     = 2'd2,
    MODE_SUM    = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

endpackage

// File: rtl/line_buffer.sv
// Enable-gated delay line: dout is the sample written DEPTH enables ago.
module line_buffer #(
  parameter int DW    = 8,
  parameter int DEPTH = 640
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          en,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];

  assign dout = mem_q[DEPTH-1];

  // Shift one position per enable, newest sample at index 0.
  always_comb begin
    mem_d = mem_q;
    if (en) begin
      mem_d[0] = din;
      for (int i = 1; i < DEPTH; i++) mem_d[i] = mem_q[i-1];
    end
  end

  // Storage register, cleared on reset.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/sobel_enhance_stream.sv
// Streaming 3x3 Sobel edge enhancer: raster pixels in, one enhanced pixel out per input pixel.
// Handshake: a pixel transfers on a rising clk edge where in_valid && in_ready; in_ready is high
// in IDLE and RUN and low during FLUSH. out_valid has no backpressure and pulses once per output.
module sobel_enhance_stream
  import img_pkg::*;
#(
  parameter int DW    = IMG_DW,
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_sof,
  input  logic [DW-1:0] din,
  input  logic [1:0]    mode,
  input  logic [1:0]    gain,
  output logic          out_valid,
  output logic          out_sof,
  output logic [DW-1:0] dout
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H + 2);
  localparam int GW = DW + 4;
  localparam logic [CW-1:0] LAST_COL = CW'(IMG_W - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(IMG_H - 1);
  localparam logic [RW-1:0] END_ROW  = RW'(IMG_H + 1);

  function automatic logic signed [GW-1:0] ext(input logic [DW-1:0] p);
    return $signed({4'b0000, p});
  endfunction

  function automatic logic [GW-1:0] abs_v(input logic signed [GW-1:0] v);
    return v[GW-1] ? $unsigned(-v) : $unsigned(v);
  endfunction

  state_e          state_q, state_d;
  logic [CW-1:0]   col_q, col_d, cur_col, cen_col;
  logic [RW-1:0]   row_q, row_d, cur_row, cen_row;
  mode_e           mode_q, mode_d;
  logic [1:0]      gain_q, gain_d;
  logic            accept, sof_acc, adv, cen_ok;
  logic [DW-1:0]   pix, lb0_out, lb1_out;
  logic [DW-1:0]   win_q [3][3];
  logic [DW-1:0]   win_d [3][3];
  logic            v0_q, v0_d, sof0_q, sof0_d, brd0_q, brd0_d;
  logic            v1_q, v1_d, sof1_q, sof1_d, brd1_q, brd1_d;
  logic [GW-1:0]   ax1_q, ax1_d, ay1_q, ay1_d;
  logic [DW-1:0]   c1_q, c1_d;
  logic signed [GW-1:0] gx, gy;
  logic [GW-1:0]   mag, sum;
  logic [DW-1:0]   sat;
  logic            out_valid_q, out_valid_d, out_sof_q, out_sof_d;
  logic [DW-1:0]   dout_q, dout_d;

  assign in_ready  = (state_q != ST_FLUSH);
  assign out_valid = out_valid_q;
  assign out_sof   = out_sof_q;
  assign dout      = dout_q;

  // Transfer qualification and the position of the pixel entering the window this cycle.
  // During FLUSH the row counter runs past the frame (rows IMG_H, IMG_H+1) feeding zeros.
  always_comb begin
    accept  = in_valid && in_ready;
    sof_acc = accept && in_sof;
    adv     = sof_acc || (state_q == ST_RUN && accept) || (state_q == ST_FLUSH);
    cur_col = sof_acc ? '0 : col_q;
    cur_row = sof_acc ? '0 : row_q;
    pix     = (state_q == ST_FLUSH) ? '0 : din;
  end

  // Next-state: raster counters, frame settings and IDLE/RUN/FLUSH sequencing.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    mode_d  = mode_q;
    gain_d  = gain_q;
    if (adv) begin
      if (cur_col == LAST_COL) begin
        col_d = '0;
        row_d = cur_row + 1'b1;
      end else begin
        col_d = cur_col + 1'b1;
        row_d = cur_row;
      end
    end
    if (sof_acc) begin
      mode_d = mode_e'(mode);
      gain_d = gain;
    end
    case (state_q)
      ST_IDLE:  if (sof_acc) state_d = ST_RUN;
      ST_RUN:   if (accept && cur_row == LAST_ROW && cur_col == LAST_COL) state_d = ST_FLUSH;
      ST_FLUSH: if (cur_row == END_ROW && cur_col == '0) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Centre of the window lags the incoming pixel by IMG_W+1; tag it valid/sof/border.
  always_comb begin
    cen_ok  = (cur_row >= RW'(2)) || (cur_row == RW'(1) && cur_col != '0);
    cen_col = (cur_col == '0) ? LAST_COL : cur_col - 1'b1;
    cen_row = (cur_col == '0) ? cur_row - RW'(2) : cur_row - 1'b1;
    v0_d    = adv && cen_ok;
    sof0_d  = (cen_row == '0) && (cen_col == '0);
    brd0_d  = (cen_row == '0) || (cen_row == LAST_ROW) || (cen_col == '0) || (cen_col == LAST_COL);
  end

  // 3x3 window: shift one column left per advance; new column from line buffers and input.
  always_comb begin
    win_d = win_q;
    if (adv) begin
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[0][2] = lb1_out;
      win_d[1][2] = lb0_out;
      win_d[2][2] = pix;
    end
  end

  // Gradient stage; a mid-frame sof kills tags of the aborted frame still in flight.
  always_comb begin
    gx = (ext(win_q[0][2]) + (ext(win_q[1][2]) <<< 1) + ext(win_q[2][2]))
       - (ext(win_q[0][0]) + (ext(win_q[1][0]) <<< 1) + ext(win_q[2][0]));
    gy = (ext(win_q[2][0]) + (ext(win_q[2][1]) <<< 1) + ext(win_q[2][2]))
       - (ext(win_q[0][0]) + (ext(win_q[0][1]) <<< 1) + ext(win_q[0][2]));
    ax1_d  = abs_v(gx);
    ay1_d  = abs_v(gy);
    c1_d   = win_q[1][1];
    v1_d   = v0_q && !sof_acc;
    sof1_d = sof0_q;
    brd1_d = brd0_q;
  end

  // Magnitude select, gain shift, saturating add; border centres pass through.
  always_comb begin
    case (mode_q)
      MODE_GX:  mag = ax1_q;
      MODE_GY:  mag = ay1_q;
      MODE_SUM: mag = ax1_q + ay1_q;
      default:  mag = '0;
    endcase
    sum         = {4'b0000, c1_q} + (mag >> gain_q);
    sat         = (sum[GW-1:DW] != '0) ? '1 : sum[DW-1:0];
    out_valid_d = v1_q && !sof_acc;
    out_sof_d   = out_valid_d && sof1_q;
    dout_d      = dout_q;
    if (out_valid_d) dout_d = brd1_q ? c1_q : sat;
  end

  line_buffer #(.DW(DW), .DEPTH(IMG_W)) u_lb0 (
    .clk(clk), .nrst(nrst), .en(adv), .din(pix), .dout(lb0_out)
  );

  line_buffer #(.DW(DW), .DEPTH(IMG_W)) u_lb1 (
    .clk(clk), .nrst(nrst), .en(adv), .din(lb0_out), .dout(lb1_out)
  );

  // All state registers, asynchronously cleared.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= ST_IDLE;
      col_q       <= '0;
      row_q       <= '0;
      mode_q      <= MODE_BYPASS;
      gain_q      <= '0;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++) win_q[r][c] <= '0;
      v0_q        <= 1'b0;
      sof0_q      <= 1'b0;
      brd0_q      <= 1'b0;
      v1_q        <= 1'b0;
      sof1_q      <= 1'b0;
      brd1_q      <= 1'b0;
      ax1_q       <= '0;
      ay1_q       <= '0;
      c1_q        <= '0;
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
      dout_q      <= '0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      mode_q      <= mode_d;
      gain_q      <= gain_d;
      win_q       <= win_d;
      v0_q        <= v0_d;
      sof0_q      <= sof0_d;
      brd0_q      <= brd0_d;
      v1_q        <= v1_d;
      sof1_q      <= sof1_d;
      brd1_q      <= brd1_d;
      ax1_q       <= ax1_d;
      ay1_q       <= ay1_d;
      c1_q        <= c1_d;
      out_valid_q <= out_valid_d;
      out_sof_q   <= out_sof_d;
      dout_q      <= dout_d;
    end
  end

endmodule

// File: tb/tb_sobel_enhance_stream.sv
// Self-checking bench for sobel_enhance_stream on an 8x6 frame.
module tb_sobel_enhance_stream;

  localparam int W = 8;
  localparam int H = 6;
  localparam int NPIX = W * H;

  // Clock / reset and DUT signals
  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_sof = 1'b0;
  logic [7:0] din = 8'd0;
  logic [1:0] mode = 2'd0;
  logic [1:0] gain = 2'd0;
  logic       in_ready, out_valid, out_sof;
  logic [7:0] dout;

  int n_pass = 0;
  int n_total = 0;

  int img [H][W];
  logic [8:0] exp_q[$];
  logic [8:0] got_q[$];

  always #5 clk = ~clk;

  sobel_enhance_stream #(.DW(8), .IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .nrst(nrst), .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof),
    .din(din), .mode(mode), .gain(gain), .out_valid(out_valid), .out_sof(out_sof), .dout(dout)
  );

  // Output collector: {out_sof, dout} of every valid output, sampled on the falling edge.
  always @(negedge clk) begin
    if (nrst && out_valid) got_q.push_back({out_sof, dout});
  end

  // Reference: Sobel enhancement of img at (r,c) computed directly from the 2-D image.
  function automatic int model_px(int r, int c, int md, int gn);
    int p, gx, gy, wt, ax, ay, mag, v;
    p = img[r][c];
    if (r == 0 || r == H-1 || c == 0 || c == W-1) return p;
    gx = 0;
    gy = 0;
    for (int d = -1; d <= 1; d++) begin
      wt = (d == 0) ? 2 : 1;
      gx += wt * (img[r+d][c+1] - img[r+d][c-1]);
      gy += wt * (img[r+1][c+d] - img[r-1][c+d]);
    end
    ax = (gx < 0) ? -gx : gx;
    ay = (gy < 0) ? -gy : gy;
    case (md)
      1: mag = ax;
      2: mag = ay;
      3: mag = ax + ay;
      default: mag = 0;
    endcase
    v = p + (mag >> gn);
    return (v > 255) ? 255 : v;
  endfunction

  task automatic expect_frame(input int md, input int gn);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        exp_q.push_back({(r == 0 && c == 0), 8'(model_px(r, c, md, gn))});
  endtask

  task automatic fill_random();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) img[r][c] = int'($urandom_range(0, 255));
  endtask

  task automatic fill_step();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) img[r][c] = (c < 4) ? 0 : 200;
  endtask

  // Driver: optional idle gap, then hold one pixel until it transfers. Entered and left on a falling edge.
  task automatic send_px(input logic [7:0] px, input logic sof, input int max_gap);
    int t;
    int g;
    t = 0;
    g = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
    repeat (g) @(negedge clk);
    in_valid = 1'b1;
    in_sof = sof;
    din = px;
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) begin
      n_total++;
      $display("FAIL send_px: in_ready stayed 0 for %0d cycles, required 1", t);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_sof = 1'b0;
    din = 8'($urandom);
  endtask

  // Sends the first npix pixels of img; mode/gain scrambled right after the sof pixel.
  task automatic send_frame(input int md, input int gn, input int max_gap, input int npix);
    for (int i = 0; i < npix; i++) begin
      if (i == 0) begin
        mode = 2'(md);
        gain = 2'(gn);
      end
      send_px(8'(img[i / W][i % W]), (i == 0), max_gap);
      if (i == 0) begin
        mode = 2'($urandom);
        gain = 2'($urandom);
      end
    end
  endtask

  task automatic wait_outputs(input int n);
    int t;
    t = 0;
    while (got_q.size() < n && t < 3000) begin
      @(negedge clk);
      t++;
    end
    repeat (15) @(negedge clk);
  endtask

  // One whole frame from img: stimulus, collection and inline comparison against the model.
  task automatic test_frame_case(input string name, input int md, input int gn, input int max_gap);
    exp_q.delete();
    got_q.delete();
    expect_frame(md, gn);
    send_frame(md, gn, max_gap, NPIX);
    wait_outputs(NPIX);
    n_total++;
    if (got_q.size() != exp_q.size())
      $display("FAIL %s count: got %0d outputs, required %0d", name, got_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_total++;
      if (got_q[i] !== exp_q[i])
        $display("FAIL %s px%0d: got sof=%0b dout=%0d, required sof=%0b dout=%0d",
                 name, i, got_q[i][8], got_q[i][7:0], exp_q[i][8], exp_q[i][7:0]);
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_total++;
    if ({out_valid, out_sof, dout, in_ready} !== {1'b0, 1'b0, 8'd0, 1'b1})
      $display("FAIL reset: got valid=%0b sof=%0b dout=%0d ready=%0b, required 0 0 0 1",
               out_valid, out_sof, dout, in_ready);
    else n_pass++;
    nrst = 1'b1;
    repeat (2) @(negedge clk);
    got_q.delete();
    for (int i = 0; i < 10; i++) send_px(8'($urandom), 1'b0, 1);
    repeat (20) @(negedge clk);
    n_total++;
    if (got_q.size() != 0) $display("FAIL idle_drop: got %0d outputs, required 0", got_q.size());
    else n_pass++;
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL idle_ready: got %0b, required 1", in_ready);
    else n_pass++;
  endtask

  task automatic test_flat();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) img[r][c] = 100;
    test_frame_case("flat", 3, 0, 0);
    n_total++;
    if (got_q.size() > 1 && got_q[1] !== 9'h064)
      $display("FAIL flat_px1: got %0h, required 064", got_q[1]);
    else if (got_q.size() > 1) n_pass++;
    else $display("FAIL flat_px1: got no output, required 064");
  endtask

  task automatic test_step();
    logic [7:0] v [4];
    fill_step();
    test_frame_case("step_gx", 1, 0, 0);
    for (int i = 0; i < 4; i++) v[i] = (got_q.size() > 2*W+2+i) ? got_q[2*W+2+i][7:0] : 8'hxx;
    n_total++;
    if ({v[0], v[1], v[2], v[3]} !== {8'd0, 8'd255, 8'd255, 8'd200})
      $display("FAIL step_gx_cols2to5: got %0d %0d %0d %0d, required 0 255 255 200", v[0], v[1], v[2], v[3]);
    else n_pass++;
    test_frame_case("step_gy", 2, 0, 0);
    v[0] = (got_q.size() > 2*W+3) ? got_q[2*W+3][7:0] : 8'hxx;
    n_total++;
    if (v[0] !== 8'd0) $display("FAIL step_gy_col3: got %0d, required 0", v[0]);
    else n_pass++;
    test_frame_case("step_gain3", 1, 3, 0);
    v[0] = (got_q.size() > 2*W+3) ? got_q[2*W+3][7:0] : 8'hxx;
    v[1] = (got_q.size() > 2*W+4) ? got_q[2*W+4][7:0] : 8'hxx;
    n_total++;
    if ({v[0], v[1]} !== {8'd100, 8'd255})
      $display("FAIL step_gain3_cols3to4: got %0d %0d, required 100 255", v[0], v[1]);
    else n_pass++;
  endtask

  task automatic test_gaps();
    fill_step();
    test_frame_case("step_gain3_gaps", 1, 3, 3);
    for (int k = 0; k < 4; k++) begin
      fill_random();
      test_frame_case("random_gaps", int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 3);
    end
  endtask

  task automatic test_flush();
    int cnt;
    fill_random();
    exp_q.delete();
    got_q.delete();
    send_frame(3, 1, 0, NPIX);
    cnt = 0;
    while (!in_ready && cnt < 50) begin
      cnt++;
      @(negedge clk);
    end
    n_total++;
    if (cnt != W + 1) $display("FAIL flush_len: in_ready low %0d cycles, required %0d", cnt, W + 1);
    else n_pass++;
    n_total++;
    if (got_q.size() >= NPIX) $display("FAIL flush_last_out: got %0d outputs before flush end, required < %0d", got_q.size(), NPIX);
    else n_pass++;
    wait_outputs(NPIX);
    n_total++;
    if (got_q.size() != NPIX || in_ready !== 1'b1)
      $display("FAIL flush_done: got %0d outputs ready=%0b, required %0d ready=1", got_q.size(), in_ready, NPIX);
    else n_pass++;
  endtask

  // Back-to-back: the new sof lands one cycle after pixel 19, so old centres 0..8 are the only ones out.
  task automatic test_sof_abort();
    int md;
    int gn;
    fill_random();
    exp_q.delete();
    got_q.delete();
    expect_frame(3, 0);
    while (exp_q.size() > 9) void'(exp_q.pop_back());
    send_frame(3, 0, 0, 20);
    fill_random();
    md = int'($urandom_range(1, 3));
    gn = int'($urandom_range(0, 3));
    expect_frame(md, gn);
    send_frame(md, gn, 0, NPIX);
    wait_outputs(NPIX + 9);
    n_total++;
    if (got_q.size() != exp_q.size())
      $display("FAIL sof_abort count: got %0d outputs, required %0d", got_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_total++;
      if (got_q[i] !== exp_q[i])
        $display("FAIL sof_abort px%0d: got %0h, required %0h", i, got_q[i], exp_q[i]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    fill_random();
    got_q.delete();
    send_frame(3, 0, 0, 20);
    @(negedge clk);
    nrst = 1'b0;
    #1;
    n_total++;
    if ({out_valid, out_sof, dout, in_ready} !== {1'b0, 1'b0, 8'd0, 1'b1})
      $display("FAIL reset_mid: got valid=%0b sof=%0b dout=%0d ready=%0b, required 0 0 0 1",
               out_valid, out_sof, dout, in_ready);
    else n_pass++;
    repeat (3) @(negedge clk);
    got_q.delete();
    nrst = 1'b1;
    repeat (30) @(negedge clk);
    n_total++;
    if (got_q.size() != 0) $display("FAIL reset_mid_no_partial: got %0d outputs, required 0", got_q.size());
    else n_pass++;
    fill_random();
    test_frame_case("after_reset", 3, 2, 1);
  endtask

  initial begin
    test_reset();
    test_flat();
    test_step();
    test_gaps();
    test_flush();
    test_sof_abort();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
